// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory arbiter: FSM state encoding, grant
// identifiers and memory width codes.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE_IF = 2'd1,
    ST_ISSUE_LS = 2'd2,
    ST_RESP     = 2'd3
  } arb_state_e;

  // Width codes carried on ls_mask / mem_mask.
  typedef enum logic [1:0] {
    MASK_BYTE = 2'b00,
    MASK_HALF = 2'b01,
    MASK_WORD = 2'b10
  } mem_mask_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_LS = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection for the unified memory arbiter.
// MEM_ARB_RR_EN defined: simultaneous requests alternate based on last grant.
// MEM_ARB_RR_EN undefined: fixed LS-over-IF priority, last grant ignored.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic i_if_req,
  input  logic i_ls_req,
  input  logic i_last_grant,
  output logic o_grant_vld,
  output logic o_grant
);

`ifdef MEM_ARB_RR_EN
  // Contention goes to whichever requester was not served last
  always_comb begin
    o_grant_vld = i_if_req | i_ls_req;
    if (i_if_req && i_ls_req) begin
      o_grant = (i_last_grant == GNT_IF) ? GNT_LS : GNT_IF;
    end else begin
      o_grant = i_ls_req ? GNT_LS : GNT_IF;
    end
  end
`else
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;

  // Load/store always wins over fetch
  always_comb begin
    o_grant_vld = i_if_req | i_ls_req;
    o_grant     = i_ls_req ? GNT_LS : GNT_IF;
  end
`endif

endmodule

// File: rtl/unified_mem_arb.sv
// Unified memory arbiter: shares one memory port between the fetch (IF) and
// load/store (LS) requesters with a single transaction in flight.
// Each transaction takes three cycles: grant (IDLE), issue, response.
// Build option MEM_ARB_RR_EN: round-robin on contention instead of LS priority.
module unified_mem_arb
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ack,
  input  logic              i_ls_req,
  input  logic              i_ls_wen,
  input  logic [ADDR_W-1:0] i_ls_addr,
  input  logic [DATA_W-1:0] i_ls_wdata,
  input  logic [1:0]        i_ls_mask,
  output logic [DATA_W-1:0] o_ls_rdata,
  output logic              o_ls_ack,
  output logic              o_mem_en,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [1:0]        o_mem_mask,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_core_stall
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_grant;
  logic              w_grant_nxt;
  logic              r_ls_store;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              w_gnt_vld;
  logic              w_gnt;
  logic              w_last_grant;
  logic              w_if_resp;
  logic              w_ls_resp;
  logic              w_ls_load_resp;

`ifdef MEM_ARB_RR_EN
  logic r_last_grant;

  // Remember who was served last; reset says LS so IF wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= GNT_LS;
    end else if (w_if_resp || w_ls_resp) begin
      r_last_grant <= r_grant;
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = GNT_IF;
`endif

  mem_arb_grant u_grant (
    .i_if_req     (i_if_req),
    .i_ls_req     (i_ls_req),
    .i_last_grant (w_last_grant),
    .o_grant_vld  (w_gnt_vld),
    .o_grant      (w_gnt)
  );

  // State, grant, store flag and read-data holding registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= GNT_IF;
      r_ls_store <= 1'b0;
      r_if_rdata <= '0;
      r_ls_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      if (r_state == ST_ISSUE_LS) begin
        r_ls_store <= i_ls_wen;
      end
      if (w_if_resp) begin
        r_if_rdata <= i_mem_rdata;
      end
      if (w_ls_load_resp) begin
        r_ls_rdata <= i_mem_rdata;
      end
    end
  end

  // Next-state decode and memory port drive; port is idle outside ISSUE
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    o_mem_en    = 1'b0;
    o_mem_wen   = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_mask  = '0;
    w_if_resp   = 1'b0;
    w_ls_resp   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_grant_nxt = w_gnt;
          w_state_nxt = (w_gnt == GNT_LS) ? ST_ISSUE_LS : ST_ISSUE_IF;
        end
      end
      ST_ISSUE_IF: begin
        o_mem_en    = 1'b1;
        o_mem_addr  = i_if_addr;
        w_state_nxt = ST_RESP;
      end
      ST_ISSUE_LS: begin
        o_mem_en    = 1'b1;
        o_mem_wen   = i_ls_wen;
        o_mem_addr  = i_ls_addr;
        o_mem_wdata = i_ls_wdata;
        o_mem_mask  = i_ls_mask;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        w_if_resp   = (r_grant == GNT_IF);
        w_ls_resp   = (r_grant == GNT_LS);
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Reset masks the port and the acks in the same cycle it is asserted
    if (!rst_n) begin
      o_mem_en    = 1'b0;
      o_mem_wen   = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_mask  = '0;
      w_if_resp   = 1'b0;
      w_ls_resp   = 1'b0;
    end
  end

  assign w_ls_load_resp = w_ls_resp & ~r_ls_store;

  // Read data is presented straight from memory in the ack cycle, then held
  assign o_if_rdata   = w_if_resp ? i_mem_rdata : r_if_rdata;
  assign o_ls_rdata   = w_ls_load_resp ? i_mem_rdata : r_ls_rdata;
  assign o_if_ack     = w_if_resp;
  assign o_ls_ack     = w_ls_resp;
  assign o_core_stall = (i_if_req & ~o_if_ack) | (i_ls_req & ~o_ls_ack);

endmodule
